// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared constants and FSM encoding for the sequential restoring divider
package div_pkg;

  localparam int DEF_WIDTH = 4;
  localparam int DEF_CNT_W = $clog2(DEF_WIDTH + 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CALC = 2'b01,
    ST_FIN  = 2'b10
  } div_state_e;

  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/div_sub_step.sv
// rtl/div_sub_step.sv - one combinational restoring shift-and-subtract iteration
module div_sub_step
  import div_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH:0]   rem_in,
  input  logic             q_msb,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH:0]   rem_out,
  output logic             q_bit
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;

  assign shifted = {rem_in[WIDTH-1:0], q_msb};
  // Subtract as add of the inverted operand with carry-in 1, like the add/sub datapath
  assign trial   = shifted + {1'b1, ~divisor} + {{WIDTH{1'b0}}, 1'b1};
  assign q_bit   = ~trial[WIDTH];
  assign rem_out = q_bit ? trial : shifted;

endmodule

// File: rtl/seq_divider_4bit.sv
// rtl/seq_divider_4bit.sv - multi-cycle restoring divider with start/done handshake
// Optional two's-complement operation when SIGNED_DIV_EN is defined.
module seq_divider_4bit
  import div_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CNT_W = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  div_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH:0]   rem_q, rem_d;
  logic [WIDTH-1:0] qsr_q, qsr_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rmd_q, rmd_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH:0]   step_rem;
  logic             step_qbit;
  logic [WIDTH-1:0] q_next;
  logic [WIDTH-1:0] dvd_mag, dvs_mag, fix_q, fix_r;

  div_sub_step #(.WIDTH(WIDTH)) u_step (
    .rem_in  (rem_q),
    .q_msb   (qsr_q[WIDTH-1]),
    .divisor (dvs_q),
    .rem_out (step_rem),
    .q_bit   (step_qbit)
  );

  assign q_next = {qsr_q[WIDTH-2:0], step_qbit};

`ifdef SIGNED_DIV_EN
  logic negq_q, negq_d;
  logic negr_q, negr_d;

  assign dvd_mag = dividend[WIDTH-1] ? (~dividend + WIDTH'(1)) : dividend;
  assign dvs_mag = divisor[WIDTH-1]  ? (~divisor + WIDTH'(1))  : divisor;
  assign fix_q   = negq_q ? (~q_next + WIDTH'(1)) : q_next;
  assign fix_r   = negr_q ? (~step_rem[WIDTH-1:0] + WIDTH'(1)) : step_rem[WIDTH-1:0];

  always_comb begin
    negq_d = negq_q;
    negr_d = negr_q;
    if (state_q == ST_IDLE && start) begin
      negq_d = dividend[WIDTH-1] ^ divisor[WIDTH-1];
      negr_d = dividend[WIDTH-1];
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      negq_q <= 1'b0;
      negr_q <= 1'b0;
    end else begin
      negq_q <= negq_d;
      negr_q <= negr_d;
    end
  end
`else
  assign dvd_mag = dividend;
  assign dvs_mag = divisor;
  assign fix_q   = q_next;
  assign fix_r   = step_rem[WIDTH-1:0];
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    qsr_d   = qsr_q;
    dvs_d   = dvs_q;
    quo_d   = quo_q;
    rmd_d   = rmd_q;
    dbz_d   = dbz_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          cnt_d = '0;
          rem_d = '0;
          qsr_d = dvd_mag;
          dvs_d = dvs_mag;
          if (divisor == '0) begin
            state_d = ST_FIN;
            quo_d   = '1;
            rmd_d   = dividend;
            dbz_d   = 1'b1;
          end else begin
            state_d = ST_CALC;
          end
        end
      end
      ST_CALC: begin
        rem_d = step_rem;
        qsr_d = q_next;
        cnt_d = cnt_q + CNT_W'(1);
        // Results are published on the same edge that enters FIN
        if (cnt_q == LAST_STEP) begin
          state_d = ST_FIN;
          quo_d   = fix_q;
          rmd_d   = fix_r;
          dbz_d   = 1'b0;
        end
      end
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      qsr_q   <= '0;
      dvs_q   <= '0;
      quo_q   <= '0;
      rmd_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      qsr_q   <= qsr_d;
      dvs_q   <= dvs_d;
      quo_q   <= quo_d;
      rmd_q   <= rmd_d;
      dbz_q   <= dbz_d;
    end
  end

  assign busy        = (state_q != ST_IDLE);
  assign done        = (state_q == ST_FIN);
  assign quotient    = quo_q;
  assign remainder   = rmd_q;
  assign div_by_zero = dbz_q;

endmodule
